// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: snoop-side MESI responder (lookup, ack, FlushOpt, Flush, state update).
// Define MESI_SNOOP_SHARED_FWD_EN to let S lines supply data cache-to-cache.
module mesi_snoop_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int WAYS = 4,
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [1:0]            bus_op,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  tag_rd_en,
  output logic [ADDR_WIDTH-1:0] tag_rd_addr,
  input  logic                  tag_hit,
  input  logic [WAY_BITS-1:0]   tag_way,
  input  logic [1:0]            tag_state,
  input  logic [LINE_WIDTH-1:0] data_rd_line,
  output logic                  resp_valid,
  output logic                  resp_match,
  output logic [1:0]            resp_state,
  input  logic                  resp_ready,
  output logic                  flushopt_valid,
  output logic [LINE_WIDTH-1:0] flushopt_data,
  input  logic                  flushopt_ready,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [LINE_WIDTH-1:0] wb_data,
  input  logic                  wb_ready,
  output logic                  st_we,
  output logic [WAY_BITS-1:0]   st_way,
  output logic [ADDR_WIDTH-1:0] st_addr,
  output logic [1:0]            st_state,
  output logic                  snoop_busy,
  output logic                  proto_err
);
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, XFER, WB, UPD} state_t;
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b11;
  localparam logic [1:0] OP_RD = 2'b01, OP_UPGR = 2'b11;
`ifdef MESI_SNOOP_SHARED_FWD_EN
  localparam bit SHARED_FWD = 1'b1;
`else
  localparam bit SHARED_FWD = 1'b0;
`endif
  state_t                r_fsm, w_nxt;
  logic [1:0]            r_op, r_eff;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WAY_BITS-1:0]   r_way;
  logic [LINE_WIDTH-1:0] r_data;
  logic                  r_perr;
  logic [1:0]            w_eff, w_nst;
  logic                  w_fo, w_fl, w_chg;
  assign w_eff = tag_hit ? tag_state : ST_I;
  // E/M always forward; S forwards only when shared forwarding is built in; BusUpgr never carries data
  assign w_fo  = (r_op != OP_UPGR) && (r_eff[1] || (SHARED_FWD && r_eff == ST_S));
  assign w_fl  = r_eff == ST_M;
  assign w_nst = (r_op == OP_RD) ? ST_S : ST_I;
  assign w_chg = (r_eff != ST_I) && (w_nst != r_eff);
  always_comb begin
    w_nxt = r_fsm;
    case (r_fsm)
      IDLE:    w_nxt = (bus_valid && |bus_op) ? LOOKUP : IDLE;
      LOOKUP:  w_nxt = RESP;
      RESP:    w_nxt = !resp_ready ? RESP : w_fo ? XFER : w_fl ? WB : w_chg ? UPD : IDLE;
      XFER:    w_nxt = !flushopt_ready ? XFER : w_fl ? WB : UPD;
      WB:      w_nxt = wb_ready ? UPD : WB;
      UPD:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= IDLE;
      r_op   <= '0;
      r_eff  <= '0;
      r_addr <= '0;
      r_way  <= '0;
      r_data <= '0;
      r_perr <= 1'b0;
    end else begin
      r_fsm <= w_nxt;
      if (bus_ready && bus_valid) begin
        r_op   <= bus_op;
        r_addr <= bus_addr;
        if (bus_op == 2'b00) r_perr <= 1'b1;
      end
      if (r_fsm == LOOKUP) begin
        r_eff  <= w_eff;
        r_way  <= tag_way;
        r_data <= data_rd_line;
        if (r_op == OP_UPGR && w_eff[1]) r_perr <= 1'b1;
      end
    end
  end
  assign bus_ready      = (r_fsm == IDLE) && !rst;
  assign tag_rd_en      = bus_ready && bus_valid && |bus_op;
  assign tag_rd_addr    = tag_rd_en ? bus_addr : '0;
  assign resp_valid     = r_fsm == RESP;
  assign resp_match     = resp_valid && (r_eff != ST_I);
  assign resp_state     = resp_valid ? r_eff : ST_I;
  assign flushopt_valid = r_fsm == XFER;
  assign flushopt_data  = flushopt_valid ? r_data : '0;
  assign wb_valid       = r_fsm == WB;
  assign wb_addr        = wb_valid ? r_addr : '0;
  assign wb_data        = wb_valid ? r_data : '0;
  assign st_we          = r_fsm == UPD;
  assign st_way         = st_we ? r_way : '0;
  assign st_addr        = st_we ? r_addr : '0;
  assign st_state       = st_we ? w_nst : ST_I;
  assign snoop_busy     = r_fsm != IDLE;
  assign proto_err      = r_perr;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb_mesi_snoop_responder: directed checks of the MESI snoop responder.
module tb_mesi_snoop_responder;
  localparam int AW = 32, LW = 256, WB_ = 2;
  logic clk = 0, rst = 1;
  logic bus_valid = 0, bus_ready;
  logic [1:0] bus_op = 0;
  logic [AW-1:0] bus_addr = 0;
  logic tag_rd_en;
  logic [AW-1:0] tag_rd_addr;
  logic tag_hit = 0;
  logic [WB_-1:0] tag_way = 0;
  logic [1:0] tag_state = 0;
  logic [LW-1:0] data_rd_line = 0;
  logic resp_valid, resp_match, resp_ready = 1;
  logic [1:0] resp_state;
  logic flushopt_valid, flushopt_ready = 1;
  logic [LW-1:0] flushopt_data;
  logic wb_valid, wb_ready = 1;
  logic [AW-1:0] wb_addr;
  logic [LW-1:0] wb_data;
  logic st_we;
  logic [WB_-1:0] st_way;
  logic [AW-1:0] st_addr;
  logic [1:0] st_state;
  logic snoop_busy, proto_err;
  int n_chk = 0, n_err = 0;
  int n_st = 0, n_fo = 0, n_wb = 0;
  int s_st, s_fo, s_wb;
  localparam logic [LW-1:0] D_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] D_5A = {32{8'h5A}};

  mesi_snoop_responder dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
    .bus_addr(bus_addr), .tag_rd_en(tag_rd_en), .tag_rd_addr(tag_rd_addr), .tag_hit(tag_hit),
    .tag_way(tag_way), .tag_state(tag_state), .data_rd_line(data_rd_line),
    .resp_valid(resp_valid), .resp_match(resp_match), .resp_state(resp_state),
    .resp_ready(resp_ready), .flushopt_valid(flushopt_valid), .flushopt_data(flushopt_data),
    .flushopt_ready(flushopt_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .st_we(st_we), .st_way(st_way), .st_addr(st_addr), .st_state(st_state),
    .snoop_busy(snoop_busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (st_we) n_st++;
    if (flushopt_valid && flushopt_ready) n_fo++;
    if (wb_valid && wb_ready) n_wb++;
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    s_st = n_st;
    s_fo = n_fo;
    s_wb = n_wb;
  endtask

  // presents one snoop for a single cycle (T0) with the given lookup result; returns at T1
  task automatic start(input logic [1:0] op, input logic [AW-1:0] a, input logic hit,
                       input logic [1:0] st, input logic [WB_-1:0] w, input logic [LW-1:0] d);
    bus_valid = 1; bus_op = op; bus_addr = a;
    tag_hit = hit; tag_state = st; tag_way = w; data_rd_line = d;
    tick;
    bus_valid = 0;
  endtask

  initial begin
    tick; tick;
    check("rst_bus_ready", bus_ready, 0);
    check("rst_busy", snoop_busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_proto_err", proto_err, 0);
    rst = 0;
    #1;
    check("idle_bus_ready", bus_ready, 1);

    // miss
    snap;
    bus_valid = 1; bus_op = 2'b01; bus_addr = 32'h100; tag_hit = 0;
    #1;
    check("miss_tag_rd_en", tag_rd_en, 1);
    check("miss_tag_rd_addr", tag_rd_addr, 32'h100);
    tick; bus_valid = 0;
    check("miss_t1_busy", snoop_busy, 1);
    check("miss_t1_bus_ready", bus_ready, 0);
    check("miss_t1_resp", resp_valid, 0);
    tick;
    check("miss_t2_resp_valid", resp_valid, 1);
    check("miss_t2_match", resp_match, 0);
    check("miss_t2_state", resp_state, 2'b00);
    tick;
    check("miss_t3_idle", snoop_busy, 0);
    check("miss_t3_bus_ready", bus_ready, 1);
    check("miss_no_events", (n_st - s_st) + (n_fo - s_fo) + (n_wb - s_wb), 0);

    // E hit, BusRd
    snap;
    start(2'b01, 32'h200, 1, 2'b10, 2, D_A5);
    tick;
    check("e_rd_resp_valid", resp_valid, 1);
    check("e_rd_match", resp_match, 1);
    check("e_rd_state", resp_state, 2'b10);
    tick;
    check("e_rd_fo_valid", flushopt_valid, 1);
    check("e_rd_fo_data", flushopt_data, D_A5);
    tick;
    check("e_rd_st_we", st_we, 1);
    check("e_rd_st_state", st_state, 2'b01);
    check("e_rd_st_way", st_way, 2);
    check("e_rd_st_addr", st_addr, 32'h200);
    tick;
    check("e_rd_idle", snoop_busy, 0);
    check("e_rd_no_wb", n_wb - s_wb, 0);
    check("e_rd_one_st", n_st - s_st, 1);

    // M hit, BusRdX, memory stalls writeback for 3 cycles
    snap;
    wb_ready = 0;
    start(2'b10, 32'h300, 1, 2'b11, 1, D_5A);
    tick;
    check("m_rdx_resp_state", resp_state, 2'b11);
    tick;
    check("m_rdx_fo_valid", flushopt_valid, 1);
    check("m_rdx_fo_data", flushopt_data, D_5A);
    tick;
    for (int i = 0; i < 3; i++) begin
      check("m_rdx_wb_valid", wb_valid, 1);
      check("m_rdx_wb_addr", wb_addr, 32'h300);
      check("m_rdx_wb_data", wb_data, D_5A);
      check("m_rdx_wb_no_st", st_we, 0);
      tick;
    end
    wb_ready = 1;
    #1;
    check("m_rdx_wb_valid4", wb_valid, 1);
    tick;
    check("m_rdx_st_we", st_we, 1);
    check("m_rdx_st_state", st_state, 2'b00);
    tick;
    check("m_rdx_idle", snoop_busy, 0);
    check("m_rdx_one_wb", n_wb - s_wb, 1);

    // S hit, BusUpgr: invalidate only
    snap;
    start(2'b11, 32'h400, 1, 2'b01, 3, D_A5);
    tick;
    check("s_upg_state", resp_state, 2'b01);
    check("s_upg_match", resp_match, 1);
    tick;
    check("s_upg_st_we", st_we, 1);
    check("s_upg_st_state", st_state, 2'b00);
    check("s_upg_no_fo", flushopt_valid, 0);
    tick;
    check("s_upg_idle", snoop_busy, 0);
    check("s_upg_no_data", (n_fo - s_fo) + (n_wb - s_wb), 0);
    check("s_upg_no_perr", proto_err, 0);

    // E hit, BusUpgr: protocol error
    start(2'b11, 32'h480, 1, 2'b10, 0, D_A5);
    tick;
    check("e_upg_state", resp_state, 2'b10);
    tick;
    check("e_upg_st_state", st_state, 2'b00);
    check("e_upg_perr", proto_err, 1);
    tick;

    // response held off for 5 cycles
    resp_ready = 0;
    start(2'b01, 32'h500, 1, 2'b10, 1, D_A5);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", resp_valid, 1);
      check("hold_resp_state", resp_state, 2'b10);
      check("hold_resp_match", resp_match, 1);
      check("hold_busy", snoop_busy, 1);
      check("hold_bus_ready", bus_ready, 0);
      tick;
    end
    resp_ready = 1;
    tick;
    check("hold_then_xfer", flushopt_valid, 1);
    tick; tick;
    check("hold_idle", snoop_busy, 0);

    // reset during XFER
    snap;
    flushopt_ready = 0;
    start(2'b01, 32'h600, 1, 2'b10, 2, D_5A);
    tick; tick;
    check("rst_xfer_fo_valid", flushopt_valid, 1);
    rst = 1;
    tick;
    check("rst_xfer_fo_off", flushopt_valid, 0);
    check("rst_xfer_busy", snoop_busy, 0);
    check("rst_xfer_perr", proto_err, 0);
    check("rst_xfer_bus_ready", bus_ready, 0);
    rst = 0; flushopt_ready = 1;
    tick; tick;
    check("rst_xfer_no_st", n_st - s_st, 0);
    check("rst_xfer_no_wb", n_wb - s_wb, 0);

    // S hit, BusRd
    snap;
    start(2'b01, 32'h700, 1, 2'b01, 1, D_A5);
    tick;
    check("s_rd_match", resp_match, 1);
    check("s_rd_state", resp_state, 2'b01);
    tick;
`ifdef MESI_SNOOP_SHARED_FWD_EN
    check("s_rd_fo_valid", flushopt_valid, 1);
    check("s_rd_fo_data", flushopt_data, D_A5);
    tick;
    check("s_rd_st_state", st_state, 2'b01);
    tick;
`else
    check("s_rd_no_fo", flushopt_valid, 0);
    check("s_rd_no_st", st_we, 0);
`endif
    check("s_rd_idle", snoop_busy, 0);

    // reserved op
    bus_valid = 1; bus_op = 2'b00; bus_addr = 32'h800;
    #1;
    check("rsv_bus_ready", bus_ready, 1);
    check("rsv_no_lookup", tag_rd_en, 0);
    tick; bus_valid = 0;
    check("rsv_stay_idle", snoop_busy, 0);
    check("rsv_perr", proto_err, 1);
    tick;
    check("rsv_no_resp", resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
